// File: rtl/calc_pkg.sv
// Shared definitions for the calculator command sequencer: command codes,
// ALU operation codes, register-bank ids and the sequencer state encoding.
package calc_pkg;

    // Front-end command codes
    typedef enum logic [1:0] {
        CMD_LOAD_A  = 2'b00,
        CMD_LOAD_B  = 2'b01,
        CMD_OPERA   = 2'b10,
        CMD_LER_ACC = 2'b11
    } comando_t;

    // ALU operation codes
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_ula_t;

    // Register-bank ids
    localparam logic [1:0] REG_A   = 2'b00;
    localparam logic [1:0] REG_B   = 2'b01;
    localparam logic [1:0] REG_ACC = 2'b10;

    // Sequencer states
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        ESCREVE = 3'd1,
        LE      = 3'd2,
        ESPERA  = 3'd3,
        GRAVA   = 3'd4,
        FIM     = 3'd5
    } estado_t;

endpackage

// File: rtl/ula_calc.sv
// Combinational ALU: ADD/SUB modulo 2^LARGURA with signed overflow, AND/OR
// with overflow forced low, and a zero flag on the result.
module ula_calc
    import calc_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    input  logic [1:0]         op,
    output logic [LARGURA-1:0] result,
    output logic               zero,
    output logic               overflow
);

    // Operation select and signed-overflow detection from the sign bits
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_ADD: begin
                result   = a + b;
                overflow = (a[LARGURA-1] == b[LARGURA-1]) &&
                           (result[LARGURA-1] != a[LARGURA-1]);
            end
            OP_SUB: begin
                result   = a - b;
                overflow = (a[LARGURA-1] != b[LARGURA-1]) &&
                           (result[LARGURA-1] != a[LARGURA-1]);
            end
            OP_AND:  result = a & b;
            default: result = a | b;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/controle_calc.sv
// Command sequencer for the calculator's three-register bank. Accepts one
// command at a time, drives the bank write/read ports, runs the ALU for
// OPERA and reports completion with a one-cycle Pronto pulse.
// Handshake: a command is taken on a rising edge where Inicia=1 and the
// sequencer is in OCIOSO (Ocupado=0); Inicia at any other time is dropped.
// Every output is loaded on the edge that enters the state it belongs to.
module controle_calc
    import calc_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Inicia,
    input  logic [1:0]         Comando,
    input  logic [1:0]         OpUla,
    input  logic [LARGURA-1:0] Operando,
    output logic [1:0]         IdReg,
    output logic [1:0]         Fonte1,
    output logic [1:0]         Fonte2,
    output logic               Escrita,
    output logic [LARGURA-1:0] Dado,
    input  logic [LARGURA-1:0] DadoLido1,
    input  logic [LARGURA-1:0] DadoLido2,
    output logic               Ocupado,
    output logic               Pronto,
    output logic [LARGURA-1:0] Resultado,
    output logic               Zero,
    output logic               Overflow,
    output logic [2:0]         Estado
);

    estado_t            estado;
    logic [1:0]         cmd_q;
    logic [1:0]         op_q;
    logic [LARGURA-1:0] operando_q;
    logic               zero_p;
    logic               ovf_p;

    logic [LARGURA-1:0] ula_res;
    logic               ula_zero;
    logic               ula_ovf;

    ula_calc #(.LARGURA(LARGURA)) u_ula (
        .a        (DadoLido1),
        .b        (DadoLido2),
        .op       (op_q),
        .result   (ula_res),
        .zero     (ula_zero),
        .overflow (ula_ovf)
    );

    assign Estado = estado;

    // Sequencer FSM with registered bank-port and status outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado     <= OCIOSO;
            cmd_q      <= CMD_LOAD_A;
            op_q       <= OP_ADD;
            operando_q <= '0;
            zero_p     <= 1'b0;
            ovf_p      <= 1'b0;
            IdReg      <= REG_A;
            Fonte1     <= REG_A;
            Fonte2     <= REG_B;
            Escrita    <= 1'b0;
            Dado       <= '0;
            Ocupado    <= 1'b0;
            Pronto     <= 1'b0;
            Resultado  <= '0;
            Zero       <= 1'b0;
            Overflow   <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (Inicia) begin
                        cmd_q      <= Comando;
                        op_q       <= OpUla;
                        operando_q <= Operando;
                        Ocupado    <= 1'b1;
                        if (Comando == CMD_LOAD_A || Comando == CMD_LOAD_B) begin
                            estado  <= ESCREVE;
                            Escrita <= 1'b1;
                            IdReg   <= (Comando == CMD_LOAD_A) ? REG_A : REG_B;
                            Dado    <= Operando;
                        end else begin
                            estado  <= LE;
                            Escrita <= 1'b0;
                            if (Comando == CMD_OPERA) begin
                                Fonte1 <= REG_A;
                                Fonte2 <= REG_B;
                            end else begin
                                Fonte1 <= REG_ACC;
                            end
                        end
                    end
                end
                ESCREVE: begin
                    estado    <= FIM;
                    Escrita   <= 1'b0;
                    Pronto    <= 1'b1;
                    Resultado <= operando_q;
                end
                LE: begin
                    // Bank captures read data on this edge
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (cmd_q == CMD_OPERA) begin
                        estado  <= GRAVA;
                        Escrita <= 1'b1;
                        IdReg   <= REG_ACC;
                        Dado    <= ula_res;
                        zero_p  <= ula_zero;
                        ovf_p   <= ula_ovf;
                    end else begin
                        estado    <= FIM;
                        Pronto    <= 1'b1;
                        Resultado <= DadoLido1;
                    end
                end
                GRAVA: begin
                    estado    <= FIM;
                    Escrita   <= 1'b0;
                    Pronto    <= 1'b1;
                    Resultado <= Dado;
                    Zero      <= zero_p;
                    Overflow  <= ovf_p;
                end
                FIM: begin
                    estado  <= OCIOSO;
                    Pronto  <= 1'b0;
                    Escrita <= 1'b0;
                    Ocupado <= 1'b0;
                end
                default: begin
                    estado  <= OCIOSO;
                    Escrita <= 1'b0;
                    Pronto  <= 1'b0;
                    Ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/controle_calc.md
# controle_calc

Command sequencer that drives the write and read ports of the calculator's three-register bank, which holds operand A, operand B and the accumulator. It accepts one command at a time from the front end: load A, load B, operate, or read accumulator. For an operate command it reads A and B through the bank's read ports, computes the result and writes it back to the accumulator. It signals completion with a one-cycle `Pronto` pulse and the result value.

## Interface
- `LARGURA`, 32, data width; must match the register bank.
- `Clock`  in  1  single clock, all state on rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Inicia`  in  1  command strobe; accepted only when `Ocupado`=0.
- `Comando`  in  2  00 LOAD_A, 01 LOAD_B, 10 OPERA, 11 LER_ACC.
- `OpUla`  in  2  for OPERA: 00 ADD, 01 SUB, 10 AND, 11 OR.
- `Operando`  in  LARGURA  value for LOAD_A/LOAD_B.
- `IdReg`  out  2  bank write-register id (00 A, 01 B, 10 ACC).
- `Fonte1`, `Fonte2`  out  2  bank read-register ids.
- `Escrita`  out  1  bank write enable.
- `Dado`  out  LARGURA  bank write data.
- `DadoLido1`, `DadoLido2`  in  LARGURA  bank read data.
- `Ocupado`  out  1  high in every state except OCIOSO.
- `Pronto`  out  1  one-cycle completion pulse.
- `Resultado`  out  LARGURA  written/read value; held until the next `Pronto`.
- `Zero`, `Overflow`  out  1  flags of the last OPERA; held.

## Operation
- All outputs are registered. Reset values: state OCIOSO; `IdReg`=00, `Fonte1`=00, `Fonte2`=01, `Escrita`=0, `Dado`=0, `Ocupado`=0, `Pronto`=0, `Resultado`=0, `Zero`=0, `Overflow`=0.
- States: OCIOSO, ESCREVE, LE, ESPERA, GRAVA, FIM.
- OCIOSO: on `Inicia`=1, latch `Comando`, `OpUla` and `Operando`.
  - LOAD_A/LOAD_B → ESCREVE.
  - OPERA/LER_ACC → LE.
- ESCREVE: `Escrita`=1, `IdReg`=00 or 01, `Dado`=latched operand → FIM with `Resultado`=operand.
- LE: `Escrita`=0.
  - OPERA: `Fonte1`=00, `Fonte2`=01.
  - LER_ACC: `Fonte1`=10.
  - Always → ESPERA.
- ESPERA: the bank has captured its read data at the LE→ESPERA edge.
  - OPERA: sample `DadoLido1`/`DadoLido2`, compute → GRAVA.
  - LER_ACC: `Resultado`=`DadoLido1` → FIM.
- GRAVA: `Escrita`=1, `IdReg`=10, `Dado`=ALU result → FIM with `Resultado`=ALU result and flags updated.
- FIM: `Pronto`=1, `Escrita`=0 → OCIOSO.
- ALU arithmetic is modulo 2^LARGURA.
  - `Zero` = result==0.
  - `Overflow` is signed overflow for ADD/SUB and 0 for AND/OR.
- `Escrita` is 1 only in ESCREVE and GRAVA, and 0 in every read state, so the bank's read gating is satisfied.

## Timing
- Accept edge = cycle 0.
- LOAD_A/LOAD_B: `Escrita` high in cycle 1 (the bank writes on the falling edge inside cycle 1); `Pronto` in cycle 2.
- OPERA: `Fonte` valid cycle 1; data sampled at the end of cycle 2; `Escrita` high in cycle 3; `Pronto` in cycle 4.
- LER_ACC: `Pronto` in cycle 3.
- The next command can be accepted in the cycle after `Pronto`. `Inicia` while `Ocupado`=1, including the FIM cycle, is ignored and not queued.
- `Operando`, `Comando` and `OpUla` may change freely after the accept edge.
- Reset mid-operation: all outputs return to reset values at that edge. No partial write occurs after the reset edge, and no `Pronto` is generated.
- `Reset` and `Inicia` asserted together: reset wins and the command is dropped.

## Structure
- Package `calc_pkg` holds:
  - command codes;
  - ALU op codes;
  - register ids (REG_A=00, REG_B=01, REG_ACC=10);
  - state encoding.
- Sub-module `ula_calc`: combinational ALU with inputs A, B, op and outputs result, zero, overflow.
- Verify against a behavioural model of the three-register bank that writes on the falling edge and reads on the rising edge when `Escrita`=0.

## Test plan
- After reset, check all outputs at their reset values. Then issue LOAD_A 5 → `Escrita`=1, `IdReg`=00, `Dado`=5 in cycle 1; `Pronto` in cycle 2 with `Resultado`=5.
- LOAD_A 7, LOAD_B 3, OPERA SUB → `Fonte1`=00/`Fonte2`=01 in cycle 1; `Escrita`=1, `IdReg`=10, `Dado`=4 in cycle 3; `Pronto` in cycle 4; `Zero`=0. A following LER_ACC returns 4 in cycle 3.
- A=0x7FFFFFFF, B=1, ADD → `Resultado`=0x80000000, `Overflow`=1. Then A=5, B=5, SUB → `Resultado`=0, `Zero`=1, `Overflow`=0.
- A=0xF0F0F0F0, B=0x0FF00FF0: AND → 0x00F000F0; OR → 0xFFF0FFF0.
- Pulse `Inicia` every cycle during an OPERA → only the first command executes; exactly one `Pronto`.
- Assert `Reset` in cycle 2 of an OPERA → `Escrita` never goes high, no `Pronto`, accumulator unchanged; the next LER_ACC returns the old value.
